// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch constants: FSM state encoding, reset PC default, NOP word
//
// Purpose: constants shared by the instruction fetch unit and its PC register.
// Ports:   none (package).

package cpu_pkg;

  // Fetch FSM state encoding (2 bits)
  localparam logic [1:0] ST_FETCH = 2'd0;  // request issued this cycle
  localparam logic [1:0] ST_WAIT  = 2'd1;  // waiting for memory ack
  localparam logic [1:0] ST_DROP  = 2'd2;  // waiting to discard a squashed ack
  localparam logic [1:0] ST_VALID = 2'd3;  // instruction presented to decoder

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with redirect load, +4 increment and alignment error pulse
//
// Purpose: holds the fetch PC. A redirect loads a force-aligned target; an
//          accepted instruction advances by 4 (wrapping modulo 2^ADDR_W).
// Ports:
//   clk_i         clock
//   rst_i         synchronous active-high reset, loads RESET_PC
//   load_i        redirect strobe; has priority over inc_i
//   load_pc_i     redirect target (low two bits are dropped)
//   inc_i         advance PC by 4
//   pc_o          current PC
//   pc_plus4_o    pc_o + 4
//   align_err_o   one-cycle pulse after a redirect to a misaligned target

module pc_reg
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT[ADDR_W-1:0]
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_pc_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              align_err_o
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              align_err_q, align_err_d;
  logic [ADDR_W-1:0] pc_plus4;

  // Natural wrap of the adder gives FFFF_FFFC + 4 = 0 with no error.
  assign pc_plus4 = pc_q + PC_STEP;

  always_comb begin
    pc_d        = pc_q;
    align_err_d = 1'b0;
    if (load_i) begin
      pc_d        = {load_pc_i[ADDR_W-1:2], 2'b00};
      align_err_d = (load_pc_i[1:0] != 2'b00);
    end else if (inc_i) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q        <= RESET_PC;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      align_err_q <= align_err_d;
    end
  end

  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_plus4;
  assign align_err_o = align_err_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS instruction fetch unit: PC, imem req/ack fetch, valid/ready output, redirects
//
// Purpose: fetches 32-bit instructions over a single-outstanding req/ack
//          memory interface and presents them to the decoder with a
//          valid/ready handshake. Redirects squash any in-flight fetch.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   imem_req_o/addr_o       fetch request and address (address = pc_o)
//   imem_ack_i/data_i       memory response strobe and instruction word
//   instr_o, pc_o           registered instruction and its address
//   pc_plus4_o              pc_o + 4
//   instr_valid_o/ready_i   output handshake
//   redirect_i/redirect_pc_i control-flow change and target
//   align_err_o             pulse after a misaligned redirect target

module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT[ADDR_W-1:0]
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_data_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              align_err_o
);

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        accept;
  logic [ADDR_W-1:0] pc;

  // Redirect beats ready, so a redirected VALID cycle never advances by 4.
  assign accept = (state_q == ST_VALID) && instr_ready_i && !redirect_i;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      // The request goes out this cycle regardless; a redirect means its
      // ack must still be absorbed, hence DROP.
      ST_FETCH: state_d = redirect_i ? ST_DROP : ST_WAIT;
      ST_WAIT: begin
        if (imem_ack_i) begin
          if (redirect_i) begin
            state_d = ST_FETCH;
          end else begin
            instr_d = imem_data_i;
            state_d = ST_VALID;
          end
        end else if (redirect_i) begin
          state_d = ST_DROP;
        end
      end
      ST_VALID: begin
        if (redirect_i || instr_ready_i) begin
          state_d = ST_FETCH;
        end
      end
      // Stay here until the squashed ack shows up, even across redirects.
      ST_DROP: begin
        if (imem_ack_i) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FETCH;
      instr_q <= NOP_WORD;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (redirect_i),
    .load_pc_i   (redirect_pc_i),
    .inc_i       (accept),
    .pc_o        (pc),
    .pc_plus4_o  (pc_plus4_o),
    .align_err_o (align_err_o)
  );

  // Gating with rst_i keeps the request low while reset is held, so no
  // fetch is issued from the FETCH state that reset forces.
  assign imem_req_o    = (state_q == ST_FETCH) && !rst_i;
  assign imem_addr_o   = pc;
  assign pc_o          = pc;
  assign instr_o       = instr_q;
  assign instr_valid_o = (state_q == ST_VALID);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the main opcode decoder.
- Owns the program counter and fetches 32-bit MIPS instructions from instruction memory over a req/ack handshake.
- Presents each instruction with a valid/ready handshake; instr_o[31:26] drives the decoder opcode input directly.
- Accepts PC redirects (beq/bne taken, j/jal, jr) computed downstream.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- ADDR_W, 32, PC and memory address width.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- imem_req_o  out  1  fetch request to instruction memory.
- imem_addr_o  out  ADDR_W  fetch address; equals pc_o while imem_req_o=1.
- imem_ack_i  in  1  memory response strobe; one cycle per accepted request.
- imem_data_i  in  32  instruction word, valid when imem_ack_i=1.
- instr_o  out  32  registered instruction; [31:26] is the opcode to the decoder.
- pc_o  out  ADDR_W  address of instr_o.
- pc_plus4_o  out  ADDR_W  pc_o+4, wraps modulo 2^ADDR_W; used for jal link and branch base.
- instr_valid_o  out  1  instr_o/pc_o valid.
- instr_ready_i  in  1  consumer accepts instr_o this cycle.
- redirect_i  in  1  control-flow change; next PC = redirect_pc_i.
- redirect_pc_i  in  ADDR_W  redirect target.
- align_err_o  out  1  one-cycle pulse when redirect_pc_i[1:0]!=0.

Behaviour:
- Reset: synchronous, active-high. With rst_i=1 at a rising edge: pc=RESET_PC, state=FETCH, imem_req_o=0, instr_valid_o=0, instr_o=32'h0, align_err_o=0. rst_i overrides every other input, including mid-fetch; a pending ack after reset is ignored (state DROP is not entered).
- States:
  - FETCH: imem_req_o=1, imem_addr_o=pc. Request is accepted the same cycle; go to WAIT.
  - WAIT: imem_req_o=0, waiting for imem_ack_i.
    - ack: latch imem_data_i into instr_o and go to VALID. instr_valid_o=1 from the next cycle, so minimum latency is req cycle + ack cycle + 1.
    - Memory may ack in the cycle immediately after the req; latency is unbounded.
  - VALID: instr_valid_o=1; instr_o and pc_o are held stable.
    - instr_ready_i=1: pc<=pc+4, instr_valid_o<=0, go to FETCH.
  - DROP: waiting for the ack of a squashed fetch. The ack is discarded (instr_o unchanged, instr_valid_o stays 0), then go to FETCH.
- Redirect (any state except reset):
  - pc <= {redirect_pc_i[ADDR_W-1:2],2'b00}; instr_valid_o<=0.
  - From FETCH: go to DROP.
  - From WAIT with no ack this cycle: go to DROP.
  - From WAIT with ack this cycle: data discarded, go to FETCH.
  - From VALID or DROP: go to FETCH. Redirect in DROP still waits? No: if ack has not arrived, stay in DROP; if it arrives this cycle, go to FETCH.
  - Redirect beats instr_ready_i when both are high; the PC is redirect target, not pc+4.
  - Back-to-back redirects: last one wins.
- align_err_o=1 for exactly the cycle after a redirect whose target has [1:0]!=0. The target is still force-aligned.
- PC wrap: 32'hFFFF_FFFC+4 = 32'h0000_0000; no error raised.
- At most one request outstanding at any time. imem_req_o is never high in WAIT, VALID, or DROP.
- instr_valid_o never drops without instr_ready_i=1, redirect_i=1, or reset.

Decomposition:
- Shared package (cpu_pkg): fetch FSM state encoding (FETCH, WAIT, DROP, VALID, 2 bits), RESET_PC default, NOP word 32'h0.
- One sub-module, pc_reg: PC register with load, increment, and align logic, plus align_err pulse generation. The FSM and instruction register stay in the top module.

Test Plan:
- Reset then ready held at 1, memory acks 1 cycle after req with data 32'h2002_0005 at PC 0 → instr_valid_o rises 3 cycles after reset release; instr_o=32'h2002_0005, pc_o=0, pc_plus4_o=4; next req address=4.
- Stall: instr_valid_o=1 with instr_ready_i=0 for 5 cycles → instr_o and pc_o stable; no imem_req_o. Ready=1 → next req address is pc+4.
- Redirect in WAIT: redirect_pc_i=32'h0000_0040 while ack pending, ack arrives 3 cycles later with 32'hDEAD_BEEF → that word never appears valid; next req address=32'h40.
- Redirect and instr_ready_i in the same VALID cycle at pc=8, target 32'h100 → next imem_addr_o=32'h100, not 32'hC.
- Misaligned redirect to 32'h0000_0013 → align_err_o pulses once; next fetch address=32'h10.
- Wrap and reset mid-fetch:
  - RESET_PC=32'hFFFF_FFFC, instruction accepted → next fetch address=0.
  - rst_i asserted during WAIT → valid=0 and req at RESET_PC next; the stale ack is ignored.
